// File: rtl/int_divrem_iter.sv
// int_divrem_iter: iterative RISC-V integer divide/remainder unit
// (DIV/DIVU/REM/REMU and their W forms). Retires BPC quotient bits per
// cycle with restoring subtract steps and optionally skips the leading
// zero bits of the dividend magnitude.
module int_divrem_iter #(
    parameter int XLEN      = 64,
    parameter int BPC       = 2,
    parameter int EARLYTERM = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Flush,
    input  logic            StartValid,
    output logic            StartReady,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      Funct3,
    input  logic            W64,
    output logic            ResultValid,
    input  logic            ResultReady,
    output logic [XLEN-1:0] Result,
    output logic            Busy
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, POST, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [1:0]      op_r;      // bit1 = remainder select, bit0 = unsigned
    logic            word_r;
    logic [XLEN-1:0] dvd;       // dividend bits still to consume, msb-aligned
    logic [XLEN-1:0] dsr;       // divisor magnitude
    logic [XLEN:0]   rem;       // partial remainder, one bit wider than operands
    logic [XLEN-1:0] quo;
    logic [CW-1:0]   cnt;
    logic            q_neg;
    logic            r_neg;
    logic            special;

    // Funct3[2] is always 1 for the divide group and carries no information.
    logic unused_funct3;
    assign unused_funct3 = Funct3[2];

    assign StartReady = (state == IDLE);
    assign Busy       = (state != IDLE);

    logic            is_signed;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] min_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] dvd_init;
    logic            a_s;
    logic            b_s;
    logic            b_zero;
    logic            ovf;
    logic [CW-1:0]   cnt_init;

    assign is_signed = ~op_r[0];

    // Operand setup: width extension, magnitudes, special cases and iteration length.
    always_comb begin
        int sig;
        int l_bits;
        // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
        a_ext            = a_r;
        b_ext            = b_r;
        min_neg          = '0;
        min_neg[XLEN-1]  = 1'b1;
        if (word_r) begin
            min_neg       = '1;
            min_neg[30:0] = '0;
            for (int i = 32; i < XLEN; i++) begin
                a_ext[i] = is_signed & a_r[31];
                b_ext[i] = is_signed & b_r[31];
            end
        end
        a_s    = is_signed & a_ext[XLEN-1];
        b_s    = is_signed & b_ext[XLEN-1];
        a_mag  = a_s ? -a_ext : a_ext;
        b_mag  = b_s ? -b_ext : b_ext;
        b_zero = (b_ext == '0);
        ovf    = is_signed && (a_ext == min_neg) && (b_ext == '1);
        sig = 0;
        for (int i = 0; i < XLEN; i++) begin
            if (a_mag[i]) sig = i + 1;
        end
        l_bits = ((sig + BPC - 1) / BPC) * BPC;
        if (l_bits == 0) l_bits = BPC;
        if (EARLYTERM == 0) l_bits = word_r ? 32 : XLEN;
        // Significant bits go to the top of the shift register so ITER always pulls from bit XLEN-1.
        dvd_init = a_mag << (XLEN - l_bits);
        cnt_init = CW'(l_bits / BPC);
    end

    logic [XLEN:0]   rem_n;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_n;
    logic [XLEN-1:0] dvd_n;

    // BPC chained restoring steps for one ITER cycle.
    always_comb begin
        rem_n = rem;
        quo_n = quo;
        dvd_n = dvd;
        diff  = '0;
        for (int k = 0; k < BPC; k++) begin
            rem_n = {rem_n[XLEN-1:0], dvd_n[XLEN-1]};
            dvd_n = dvd_n << 1;
            diff  = rem_n - {1'b0, dsr};
            if (!diff[XLEN]) begin
                rem_n = diff;
                quo_n = {quo_n[XLEN-2:0], 1'b1};
            end else begin
                quo_n = {quo_n[XLEN-2:0], 1'b0};
            end
        end
    end

    logic [XLEN-1:0] post_q;
    logic [XLEN-1:0] post_r;
    logic [XLEN-1:0] post_val;

    // Sign fix-up, quotient/remainder select and word sign extension.
    always_comb begin
        post_q   = (q_neg & ~special) ? -quo : quo;
        post_r   = (r_neg & ~special) ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        post_val = op_r[1] ? post_r : post_q;
        if (word_r) begin
            for (int i = 32; i < XLEN; i++) post_val[i] = post_val[31];
        end
    end

    // Control FSM and datapath registers; Flush returns to IDLE from any state.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            op_r        <= '0;
            word_r      <= 1'b0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            special     <= 1'b0;
            Result      <= '0;
            ResultValid <= 1'b0;
        end else if (Flush) begin
            state       <= IDLE;
            ResultValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (StartValid) begin
                        a_r    <= A;
                        b_r    <= B;
                        op_r   <= Funct3[1:0];
                        word_r <= (XLEN == 64) && W64;
                        state  <= PREP;
                    end
                end
                PREP: begin
                    q_neg <= a_s ^ b_s;
                    r_neg <= a_s;
                    dsr   <= b_mag;
                    if (b_zero) begin
                        special <= 1'b1;
                        quo     <= '1;
                        rem     <= {1'b0, a_ext};
                        state   <= POST;
                    end else if (ovf) begin
                        special <= 1'b1;
                        quo     <= a_ext;
                        rem     <= '0;
                        state   <= POST;
                    end else begin
                        special <= 1'b0;
                        quo     <= '0;
                        rem     <= '0;
                        dvd     <= dvd_init;
                        cnt     <= cnt_init;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    // The count drains to zero; the zero-count cycle hands over to POST.
                    if (cnt == '0) begin
                        state <= POST;
                    end else begin
                        rem <= rem_n;
                        quo <= quo_n;
                        dvd <= dvd_n;
                        cnt <= cnt - 1'b1;
                    end
                end
                POST: begin
                    Result      <= post_val;
                    ResultValid <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (ResultReady) begin
                        ResultValid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
